// File: rtl/naive_bus_arbiter_2to1_if.sv
// naive_bus port bundle: one single-cycle read channel and one write channel.
//
// A port is used by a requester (master modport) and a responder (slave modport).
//   rd_req/rd_gnt   read handshake; a read completes in the cycle rd_req & rd_gnt
//   rd_addr         read address, held by the requester until granted
//   rd_data         read data, valid the cycle after the completing read cycle
//   wr_req/wr_gnt   write handshake; a write completes in the cycle wr_req & wr_gnt
//   wr_addr         write address
//   wr_byte         write byte enables, one per data byte
//   wr_data         write data
// Grants are combinational from the responder in the same cycle as the request.
interface naive_bus_arbiter_2to1_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic            rd_req;
  logic            rd_gnt;
  logic [AW-1:0]   rd_addr;
  logic [DW-1:0]   rd_data;
  logic            wr_req;
  logic            wr_gnt;
  logic [AW-1:0]   wr_addr;
  logic [DW/8-1:0] wr_byte;
  logic [DW-1:0]   wr_data;

  // Requester side: drives requests, receives grants and read data.
  modport master (
    output rd_req,
    output rd_addr,
    input  rd_gnt,
    input  rd_data,
    output wr_req,
    output wr_addr,
    output wr_byte,
    output wr_data,
    input  wr_gnt
  );

  // Responder side: receives requests, drives grants and read data.
  modport slave (
    input  rd_req,
    input  rd_addr,
    output rd_gnt,
    output rd_data,
    input  wr_req,
    input  wr_addr,
    input  wr_byte,
    input  wr_data,
    output wr_gnt
  );

endinterface

// File: rtl/naive_bus_arbiter_2to1.sv
// Two-master to one-slave naive_bus arbiter.
//
// Merges the core's instruction master (m0_io) and data master (m1_io) onto one
// single-port naive_bus slave (s_io). One transaction per cycle, read or write.
// Selection is combinational; read data is steered back to the master whose read
// completed in the previous cycle.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   m0_io  instruction master port (slave modport of naive_bus_arbiter_2to1_if)
//   m1_io  data master port (slave modport)
//   s_io   shared downstream slave port (master modport)
//
// Build option:
//   NB_ARB_DATA_PRIO_EN  when defined, m1 always wins a contended cycle and the
//                        round-robin pointer is not built. When undefined, a 1-bit
//                        round-robin pointer decides contended cycles.
module naive_bus_arbiter_2to1 #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  naive_bus_arbiter_2to1_if.slave  m0_io,
  naive_bus_arbiter_2to1_if.slave  m1_io,
  naive_bus_arbiter_2to1_if.master s_io
);

  localparam int unsigned BW = DW / 8;

  // Read-data owner encoding: bit 0 = m0, bit 1 = m1, zero = nobody.
  localparam logic [1:0] OwnNone = 2'b00;

  logic          m0_act, m1_act;
  logic          sel_m0, sel_m1;
  logic          m0_rd_pick, m0_wr_pick;
  logic          m1_rd_pick, m1_wr_pick;
  logic          m0_rd_done, m1_rd_done;
  logic [AW-1:0] s_rd_addr, s_wr_addr;
  logic [BW-1:0] s_wr_byte;
  logic [DW-1:0] s_wr_data;
  logic [1:0]    rd_owner_d, rd_owner_q;

`ifndef NB_ARB_DATA_PRIO_EN
  logic          rr_ptr_d, rr_ptr_q;
  logic          xfer_done;
`endif

  // ---------------------------------------------------------------------------
  // Selection
  // ---------------------------------------------------------------------------
  always_comb begin
    m0_act = m0_io.rd_req | m0_io.wr_req;
    m1_act = m1_io.rd_req | m1_io.wr_req;
`ifdef NB_ARB_DATA_PRIO_EN
    // Data master wins any contended cycle so the memory stage never stalls on fetch.
    sel_m1 = m1_act;
`else
    // m1 wins when alone, or when contending and the pointer favours it.
    sel_m1 = m1_act & (~m0_act | rr_ptr_q);
`endif
    sel_m0 = m0_act & ~sel_m1;

    // A master raising both requests is served as a read; its write stays pending.
    m0_rd_pick = sel_m0 & m0_io.rd_req;
    m0_wr_pick = sel_m0 & ~m0_io.rd_req & m0_io.wr_req;
    m1_rd_pick = sel_m1 & m1_io.rd_req;
    m1_wr_pick = sel_m1 & ~m1_io.rd_req & m1_io.wr_req;
  end

  // ---------------------------------------------------------------------------
  // Request path to the slave: only the picked channel of the selected master is
  // forwarded, everything else is held at zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_rd_addr = '0;
    s_wr_addr = '0;
    s_wr_byte = '0;
    s_wr_data = '0;
    if (m0_rd_pick) begin
      s_rd_addr = m0_io.rd_addr;
    end else if (m1_rd_pick) begin
      s_rd_addr = m1_io.rd_addr;
    end
    if (m0_wr_pick) begin
      s_wr_addr = m0_io.wr_addr;
      s_wr_byte = m0_io.wr_byte;
      s_wr_data = m0_io.wr_data;
    end else if (m1_wr_pick) begin
      s_wr_addr = m1_io.wr_addr;
      s_wr_byte = m1_io.wr_byte;
      s_wr_data = m1_io.wr_data;
    end
  end

  assign s_io.rd_req  = m0_rd_pick | m1_rd_pick;
  assign s_io.rd_addr = s_rd_addr;
  assign s_io.wr_req  = m0_wr_pick | m1_wr_pick;
  assign s_io.wr_addr = s_wr_addr;
  assign s_io.wr_byte = s_wr_byte;
  assign s_io.wr_data = s_wr_data;

  // ---------------------------------------------------------------------------
  // Grants: the slave's grant is passed only to the picked channel.
  // ---------------------------------------------------------------------------
  assign m0_rd_done   = m0_rd_pick & s_io.rd_gnt;
  assign m1_rd_done   = m1_rd_pick & s_io.rd_gnt;

  assign m0_io.rd_gnt = m0_rd_done;
  assign m0_io.wr_gnt = m0_wr_pick & s_io.wr_gnt;
  assign m1_io.rd_gnt = m1_rd_done;
  assign m1_io.wr_gnt = m1_wr_pick & s_io.wr_gnt;

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  // Owner tracks only the current cycle's completed read, so back-to-back reads
  // from alternating masters each get their own data.
  assign rd_owner_d = {m1_rd_done, m0_rd_done};

`ifndef NB_ARB_DATA_PRIO_EN
  assign xfer_done = (s_io.rd_req & s_io.rd_gnt) | (s_io.wr_req & s_io.wr_gnt);
  // After a completed transfer point at the master that was not served; a refused
  // request leaves the pointer alone so the same master is reselected.
  assign rr_ptr_d  = xfer_done ? sel_m0 : rr_ptr_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_owner_q <= OwnNone;
`ifndef NB_ARB_DATA_PRIO_EN
      rr_ptr_q   <= 1'b0;
`endif
    end else begin
      rd_owner_q <= rd_owner_d;
`ifndef NB_ARB_DATA_PRIO_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Read-data return: unregistered steer of the slave's data.
  // ---------------------------------------------------------------------------
  assign m0_io.rd_data = rd_owner_q[0] ? s_io.rd_data : '0;
  assign m1_io.rd_data = rd_owner_q[1] ? s_io.rd_data : '0;

`ifndef SYNTHESIS
  // The slave never sees a read and a write in the same cycle.
  a_no_concurrent_rw : assert property (@(posedge clk) disable iff (!rst_n)
    !(s_io.rd_req && s_io.wr_req));

  // At most one grant is ever given.
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({m1_io.wr_gnt, m1_io.rd_gnt, m0_io.wr_gnt, m0_io.rd_gnt}));

  // Owner register never claims both masters.
  a_owner_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(rd_owner_q));
`endif

endmodule
